// File: rtl/interface_sw_pkg.sv
// Shared definitions for the switch-reader virtual JTAG node: instruction codes and parameter defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package interface_sw_pkg;

    localparam int SW_W               = 8;
    localparam int DEB_CYCLES_DEFAULT = 4;
    localparam int CNT_W_DEFAULT      = 8;

    typedef enum logic [1:0] {
        IR_BYPASS   = 2'b00,
        IR_READ_SW  = 2'b01,
        IR_READ_CNT = 2'b10,
        IR_CLR_CNT  = 2'b11
    } ir_t;

endpackage

// File: rtl/interface_sw_if.sv
// Virtual JTAG hub <-> node signal bundle (serial data, instruction, DR-state qualifiers).
// Latency: n/a (wires only); tdo is combinational from the node.
// Backpressure: none, the hub paces every scan one bit per tck.
interface interface_sw_if;
    import interface_sw_pkg::*;

    logic tdi;
    ir_t  ir_in;
    logic v_cdr;
    logic v_sdr;
    logic udr;
    logic tdo;

    modport master (output tdi, ir_in, v_cdr, v_sdr, udr, input tdo);
    modport slave  (input tdi, ir_in, v_cdr, v_sdr, udr, output tdo);

endinterface

// File: rtl/interface_sw_debounce.sv
// One switch bit: 2-flop synchronizer followed by a hold-time debouncer.
// Latency: new level accepted 2 + DEB_CYCLES tck edges after it first appears on sw_in.
// Backpressure: none; toggle is a single-cycle pulse on the edge stable flips.
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic tck,
    input  logic aclr_n,
    input  logic sw_in,
    output logic stable,
    output logic toggle
);

    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

    logic       sync_1;
    logic       sync_2;
    logic [7:0] cnt;

    // Flip happens on the edge where the mismatch has already lasted DEB_CYCLES-1 counts.
    assign toggle = (sync_2 != stable) && (cnt == CNT_LAST);

    // Two-stage synchronizer for the asynchronous switch level.
    always_ff @(posedge tck or negedge aclr_n) begin
        if (!aclr_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= sw_in;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive mismatch cycles; any agreement restarts the count.
    always_ff @(posedge tck or negedge aclr_n) begin
        if (!aclr_n) begin
            cnt    <= 8'd0;
            stable <= 1'b0;
        end else if (sync_2 == stable) begin
            cnt <= 8'd0;
        end else if (toggle) begin
            cnt    <= 8'd0;
            stable <= ~stable;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/interface_sw.sv
// Virtual JTAG node exposing 8 debounced board switches and (INTERFACE_SW_EVTCNT_EN) a switch-change counter.
// Latency: capture on the v_cdr edge, one bit per v_sdr edge, tdo combinational from the selected DR LSB.
// Backpressure: none; debounce and counting run free of any scan activity.
module interface_sw
    import interface_sw_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic              tck,
    input  logic              aclr_n,
    interface_sw_if.slave     jtag,
    input  logic [SW_W-1:0]   sw,
    output logic [SW_W-1:0]   sw_stable
);

    logic [SW_W-1:0] toggle;
    logic [SW_W-1:0] sw_dr;
    logic            byp;
    logic            cap;
    logic            shf;
    logic            sel_byp;

    for (genvar g = 0; g < SW_W; g++) begin : g_deb
        sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .tck    (tck),
            .aclr_n (aclr_n),
            .sw_in  (sw[g]),
            .stable (sw_stable[g]),
            .toggle (toggle[g])
        );
    end

    // Capture outranks shift when the hub asserts both.
    assign cap = jtag.v_cdr;
    assign shf = jtag.v_sdr && !jtag.v_cdr;

`ifdef INTERFACE_SW_EVTCNT_EN
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] cnt_dr;

    assign sel_byp = (jtag.ir_in == IR_BYPASS) || (jtag.ir_in == IR_CLR_CNT);

    // Saturating count of cycles with any accepted switch change; CLR_CNT update wins.
    always_ff @(posedge tck or negedge aclr_n) begin
        if (!aclr_n) begin
            evt_cnt <= '0;
        end else if (jtag.udr && (jtag.ir_in == IR_CLR_CNT)) begin
            evt_cnt <= '0;
        end else if ((|toggle) && (evt_cnt != {CNT_W{1'b1}})) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

    // Count DR: snapshot of the pre-increment counter, then shift LSB first.
    always_ff @(posedge tck or negedge aclr_n) begin
        if (!aclr_n) begin
            cnt_dr <= '0;
        end else if (jtag.ir_in == IR_READ_CNT) begin
            if (cap) begin
                cnt_dr <= evt_cnt;
            end else if (shf) begin
                cnt_dr <= CNT_W'({jtag.tdi, cnt_dr} >> 1);
            end
        end
    end
`else
    logic unused_ok;

    // Without the counter, the upper instruction codes fall back to bypass.
    assign sel_byp   = (jtag.ir_in != IR_READ_SW);
    assign unused_ok = ^{toggle, jtag.udr};
`endif

    // Switch DR: snapshot of the debounced levels, then shift LSB first.
    always_ff @(posedge tck or negedge aclr_n) begin
        if (!aclr_n) begin
            sw_dr <= '0;
        end else if (jtag.ir_in == IR_READ_SW) begin
            if (cap) begin
                sw_dr <= sw_stable;
            end else if (shf) begin
                sw_dr <= {jtag.tdi, sw_dr[SW_W-1:1]};
            end
        end
    end

    // One-bit bypass register follows tdi during shift.
    always_ff @(posedge tck or negedge aclr_n) begin
        if (!aclr_n) begin
            byp <= 1'b0;
        end else if (shf && sel_byp) begin
            byp <= jtag.tdi;
        end
    end

    // Serial output from the LSB of whichever DR the instruction selects.
    always_comb begin
        jtag.tdo = byp;
        if (jtag.ir_in == IR_READ_SW) begin
            jtag.tdo = sw_dr[0];
        end
`ifdef INTERFACE_SW_EVTCNT_EN
        if (jtag.ir_in == IR_READ_CNT) begin
            jtag.tdo = cnt_dr[0];
        end
`endif
    end

endmodule

// File: tb/tb_interface_sw.sv
// Bench for interface_sw: directed JTAG scans and switch patterns, expectations queued and checked by a monitor.
// Two instances share stimulus: CNT_W=8 and CNT_W=2 (saturation).
// Counter tests run only when INTERFACE_SW_EVTCNT_EN is defined; otherwise upper IR codes are checked as bypass.
`timescale 1ns/100ps
module tb_interface_sw;
    import interface_sw_pkg::*;

    localparam int SRC_TDO  = 0;
    localparam int SRC_TDO2 = 1;
    localparam int SRC_STB  = 2;
    localparam int SRC_STB2 = 3;
    localparam int TIMEOUT_NS = 200000;

    typedef struct {
        int          src;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    event mon_kick;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic done   = 1'b0;

    logic       tck    = 1'b0;
    logic       aclr_n = 1'b0;
    logic [7:0] sw     = 8'h00;
    logic [7:0] sw_stable;
    logic [7:0] sw_stable2;

    interface_sw_if jt ();
    interface_sw_if jt2 ();

    interface_sw #(.DEB_CYCLES(4), .CNT_W(8)) u_dut (
        .tck       (tck),
        .aclr_n    (aclr_n),
        .jtag      (jt),
        .sw        (sw),
        .sw_stable (sw_stable)
    );

    interface_sw #(.DEB_CYCLES(4), .CNT_W(2)) u_dut2 (
        .tck       (tck),
        .aclr_n    (aclr_n),
        .jtag      (jt2),
        .sw        (sw),
        .sw_stable (sw_stable2)
    );

    always #5 tck = ~tck;

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [15:0] sample(input int src);
        case (src)
            SRC_TDO:  return 16'(jt.tdo);
            SRC_TDO2: return 16'(jt2.tdo);
            SRC_STB:  return 16'(sw_stable);
            default:  return 16'(sw_stable2);
        endcase
    endfunction

    task automatic check_now(input int src, input logic [15:0] v, input string nm);
        logic [15:0] act;
        act = sample(src);
        n_chk++;
        if (act === v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, v);
    endtask

    task automatic expect_val(input int src, input logic [15:0] v, input string nm);
        exp_t e;
        e.src  = src;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic jset(input ir_t ir, input logic cdr, input logic sdr, input logic u, input logic d);
        jt.ir_in  = ir;
        jt.v_cdr  = cdr;
        jt.v_sdr  = sdr;
        jt.udr    = u;
        jt.tdi    = d;
        jt2.ir_in = ir;
        jt2.v_cdr = cdr;
        jt2.v_sdr = sdr;
        jt2.udr   = u;
        jt2.tdi   = d;
    endtask

    // Capture then shift n bits; tdo expected LSB first (n2 bits checked on the second instance).
    task automatic scan(input ir_t ir, input int n, input logic [15:0] exp1,
                        input int n2, input logic [15:0] exp2, input string nm);
        jset(ir, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < n; i++) begin
            jset(ir, 1'b0, 1'b1, 1'b0, 1'b0);
            expect_val(SRC_TDO, 16'(exp1[i]), $sformatf("%s_bit%0d", nm, i));
            if (i < n2) expect_val(SRC_TDO2, 16'(exp2[i]), $sformatf("%s_w2_bit%0d", nm, i));
            tick();
        end
        jset(IR_BYPASS, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Shift bits through bypass; tdo must show the previous tdi bit.
    task automatic byp_scan(input ir_t ir, input logic [7:0] bits, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            jset(ir, 1'b0, 1'b1, 1'b0, bits[i]);
            if (i > 0) begin
                expect_val(SRC_TDO, 16'(bits[i-1]), $sformatf("%s_bit%0d", nm, i));
                expect_val(SRC_TDO2, 16'(bits[i-1]), $sformatf("%s_w2_bit%0d", nm, i));
            end
            tick();
        end
        jset(IR_BYPASS, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: drain queued expectations at each falling edge or on demand.
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge tck or mon_kick);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = sample(e.src);
                n_chk++;
                if (act === e.val) n_pass++;
                else $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
            end
        end
    end

    // Watchdog: the stimulus must complete before the wait expires.
    initial begin
        #(TIMEOUT_NS);
        if (!done) begin
            $display("FAIL timeout: stimulus did not finish within %0d ns", TIMEOUT_NS);
            $finish;
        end
    end

    initial begin
        jset(IR_BYPASS, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset state.
        #2;
        check_now(SRC_TDO, 16'h0, "rst_tdo");
        check_now(SRC_STB, 16'h0, "rst_stable");
        check_now(SRC_STB2, 16'h0, "rst_stable2");
        wait_n(2);
        aclr_n = 1'b1;
        wait_n(2);

        // Glitch on bit0 shorter than the debounce window is rejected.
        sw = 8'h01;
        wait_n(3);
        sw = 8'h00;
        for (int i = 0; i < 8; i++) begin
            expect_val(SRC_STB, 16'h0, $sformatf("glitch_stable_c%0d", i));
            tick();
        end
`ifdef INTERFACE_SW_EVTCNT_EN
        scan(IR_READ_CNT, 8, 16'd0, 2, 16'd0, "glitch_cnt");
`endif

        // 00 -> A5: accepted exactly 6 edges after the change.
        sw = 8'hA5;
        wait_n(5);
        expect_val(SRC_STB, 16'h00, "a5_not_yet");
        tick();
        expect_val(SRC_STB, 16'hA5, "a5_accepted");
        expect_val(SRC_STB2, 16'hA5, "a5_accepted2");
        wait_n(4);
        scan(IR_READ_SW, 8, 16'h00A5, 8, 16'h00A5, "read_sw_a5");

`ifdef INTERFACE_SW_EVTCNT_EN
        // udr under READ_CNT must not clear; count is 1 from the A5 change.
        jset(IR_READ_CNT, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        jset(IR_BYPASS, 1'b0, 1'b0, 1'b0, 1'b0);
        scan(IR_READ_CNT, 8, 16'd1, 2, 16'd1, "udr_ignored_cnt");

        // CLR_CNT update on the same edge as an accepted toggle: clear wins.
        sw = 8'hA1;
        wait_n(5);
        jset(IR_CLR_CNT, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        jset(IR_BYPASS, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(SRC_STB, 16'hA1, "clr_toggle_stable");
        scan(IR_READ_CNT, 8, 16'd0, 2, 16'd0, "clr_cnt");

        // Separate toggles of bit1: 3, then 5 (CNT_W=2 saturates at 3).
        for (int k = 1; k <= 5; k++) begin
            sw[1] = ~sw[1];
            wait_n(8);
            if (k == 3) scan(IR_READ_CNT, 8, 16'd3, 2, 16'd3, "cnt_3");
        end
        scan(IR_READ_CNT, 8, 16'd5, 2, 16'd3, "cnt_5_sat");

        // Capture on the increment edge returns the old value.
        sw[1] = ~sw[1];
        wait_n(5);
        scan(IR_READ_CNT, 8, 16'd5, 2, 16'd3, "cap_pre_inc");
        scan(IR_READ_CNT, 8, 16'd6, 2, 16'd3, "cap_after_inc");
`else
        // Without the counter, READ_CNT code is plain bypass.
        byp_scan(IR_READ_CNT, 8'b0000_0010, 4, "ir10_bypass");
`endif

        // Bypass paths: tdi 0,1,1,0,0 -> tdo 0,1,1,0 one cycle late.
        byp_scan(IR_BYPASS, 8'b0000_0110, 5, "ir00_bypass");
        byp_scan(IR_CLR_CNT, 8'b0000_0101, 4, "ir11_bypass");

        // Asynchronous reset mid-shift.
        jset(IR_READ_SW, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        jset(IR_READ_SW, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_n(3);
        #1;
        aclr_n = 1'b0;
        #1;
        -> mon_kick;
        check_now(SRC_TDO, 16'h0, "arst_tdo");
        check_now(SRC_TDO2, 16'h0, "arst_tdo2");
        check_now(SRC_STB, 16'h0, "arst_stable");
        check_now(SRC_STB2, 16'h0, "arst_stable2");
        #1;
        aclr_n = 1'b1;
        jset(IR_BYPASS, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_n(10);
        expect_val(SRC_STB, 16'(sw), "post_rst_stable");
        scan(IR_READ_SW, 8, 16'(sw), 8, 16'(sw), "post_rst_read_sw");
`ifdef INTERFACE_SW_EVTCNT_EN
        scan(IR_READ_CNT, 8, 16'd1, 2, 16'd1, "post_rst_cnt");
`endif

        wait_n(3);
        done = 1'b1;
        if (n_pass != n_chk) $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
